// File: rtl/serial_addsub.sv
// serial_addsub -- digit-serial adder/subtractor.
//
// Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit
// first. Subtraction is a + ~b + 1: the second operand is inverted when it is
// latched and the carry is preset to 1. The result and flags are registered
// when the last digit has been processed and held until the next completion.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   DIGIT  bits processed per clock; WIDTH must be a multiple of DIGIT
//
// Ports
//   clk     in   clock, rising edge active
//   rst     in   asynchronous active-high reset
//   start   in   request a new operation (ignored while busy)
//   mode    in   0 = a + b, 1 = a - b (sampled with start)
//   a, b    in   operands (sampled with start)
//   busy    out  operation in progress
//   done    out  one-cycle pulse when result/flags are valid
//   result  out  sum or difference modulo 2^WIDTH
//   c_out   out  final carry (subtract: 1 = no borrow)
//   ovf     out  two's-complement signed overflow
//   zero    out  result == 0
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ripple-adds one digit. Returns {carry into the top bit, carry out, sum};
  // on the final digit the first field is the carry into the word MSB,
  // which the overflow flag needs.
  function automatic logic [DIGIT+1:0] digit_add(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             cin
  );
    logic             c;
    logic             c_top;
    logic [DIGIT-1:0] s;
    c     = cin;
    c_top = cin;
    s     = '0;
    for (int i = 0; i < DIGIT; i++) begin
      c_top = c;
      s[i]  = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c_top, c, s};
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic [DIGIT+1:0]   dsum;
  logic [WIDTH-1:0]   acc_shift;
  logic               accept;
  logic               last_step;

  assign dsum = digit_add(a_q[DIGIT-1:0], b_q[DIGIT-1:0], carry_q);

  // New sum digit enters at the MSB end; after STEPS shifts the first digit
  // has reached bit 0 and acc holds the full word.
  assign acc_shift = (acc_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_step = (state_q == RUN) && (cnt_q == LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath next-state
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    if (accept) begin
      a_d     = a;
      b_d     = b ^ {WIDTH{mode}};
      carry_d = mode;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      acc_d   = acc_shift;
      carry_d = dsum[DIGIT];
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_step) begin
        result_d = acc_shift;
        c_out_d  = dsum[DIGIT];
        ovf_d    = dsum[DIGIT+1] ^ dsum[DIGIT];
        zero_d   = (acc_shift == '0);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign c_out  = c_out_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub: one instance with DIGIT=1 and one with DIGIT=4,
// both WIDTH=8. Expected results are queued when an operation is started and
// compared when the instance pulses done.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start4;
  logic       mode;
  logic [7:0] a, b;

  logic       busy1, done1, c_out1, ovf1, zero1;
  logic [7:0] result1;
  logic       busy4, done4, c_out4, ovf4, zero4;
  logic [7:0] result4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] q1[$];
  logic [10:0] q4[$];
  logic [10:0] e1, e4;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .a(a), .b(b),
    .busy(busy1), .done(done1), .result(result1), .c_out(c_out1),
    .ovf(ovf1), .zero(zero1)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode), .a(a), .b(b),
    .busy(busy4), .done(done4), .result(result4), .c_out(c_out4),
    .ovf(ovf4), .zero(zero4)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {zero, ovf, c_out, result}
  function automatic logic [10:0] model(input logic m, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    logic       v;
    if (!m) begin
      s = {1'b0, x} + {1'b0, y};
      v = (x[7] == y[7]) && (s[7] != x[7]);
    end else begin
      s = {1'b0, x} + {1'b0, ~y} + 9'd1;
      v = (x[7] != y[7]) && (s[7] != x[7]);
    end
    return {(s[7:0] == 8'h00), v, s[8], s[7:0]};
  endfunction

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        check_val("d1_spurious_done", 1, 0);
      end else begin
        e1 = q1.pop_front();
        check_val("d1_result", result1, e1[7:0]);
        check_val("d1_c_out", c_out1, e1[8]);
        check_val("d1_ovf", ovf1, e1[9]);
        check_val("d1_zero", zero1, e1[10]);
      end
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) begin
        check_val("d4_spurious_done", 1, 0);
      end else begin
        e4 = q4.pop_front();
        check_val("d4_result", result4, e4[7:0]);
        check_val("d4_c_out", c_out4, e4[8]);
        check_val("d4_ovf", ovf4, e4[9]);
        check_val("d4_zero", zero4, e4[10]);
      end
    end
  end

  // Called just after a falling edge. Starts one operation, then measures the
  // cycle in which done appears and how many cycles busy was high. If inj > 0,
  // a conflicting start is pulsed on dut1 in RUN cycle inj.
  task automatic run_op(input bit sel, input logic m, input logic [7:0] x,
                        input logic [7:0] y, input int inj);
    int lat;
    int nb;
    int exp_lat;
    exp_lat = sel ? 3 : 9;
    mode = m;
    a    = x;
    b    = y;
    if (sel) begin
      start4 = 1'b1;
      q4.push_back(model(m, x, y));
    end else begin
      start1 = 1'b1;
      q1.push_back(model(m, x, y));
    end
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    lat = 1;
    nb  = 0;
    while (!(sel ? done4 : done1) && lat < 20) begin
      if (sel ? busy4 : busy1) nb++;
      if (inj > 0 && lat == inj) begin
        start1 = 1'b1;
        mode   = ~m;
        a      = ~x;
        b      = 8'h5A;
      end else begin
        start1 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start1 = 1'b0;
    check_val(sel ? "d4_latency" : "d1_latency", lat, exp_lat);
    check_val(sel ? "d4_busy_cycles" : "d1_busy_cycles", nb, exp_lat - 1);
    check_val(sel ? "d4_busy_at_done" : "d1_busy_at_done", sel ? busy4 : busy1, 0);
  endtask

  initial begin
    bit saw;
    rst    = 1'b1;
    start1 = 1'b0;
    start4 = 1'b0;
    mode   = 1'b0;
    a      = 8'h00;
    b      = 8'h00;
    repeat (2) @(negedge clk);

    check_val("rst_busy1", busy1, 0);
    check_val("rst_done1", done1, 0);
    check_val("rst_result1", result1, 0);
    check_val("rst_c_out1", c_out1, 0);
    check_val("rst_ovf1", ovf1, 0);
    check_val("rst_zero1", zero1, 0);
    check_val("rst_busy4", busy4, 0);
    check_val("rst_done4", done4, 0);
    check_val("rst_result4", result4, 0);

    // Start on the first edge after reset release, then a back-to-back chain
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 1'b1, 8'h05, 8'h03, 0);
    run_op(0, 1'b1, 8'h03, 8'h05, 0);
    run_op(0, 1'b1, 8'h80, 8'h01, 0);
    run_op(0, 1'b0, 8'hFF, 8'h01, 0);
    run_op(0, 1'b1, 8'h5A, 8'h5A, 0);
    run_op(0, 1'b0, 8'h7F, 8'h01, 0);

    // Outputs hold after returning to IDLE
    repeat (4) @(negedge clk);
    check_val("hold_done", done1, 0);
    check_val("hold_busy", busy1, 0);
    check_val("hold_result", result1, 8'h80);
    check_val("hold_ovf", ovf1, 1);

    // Conflicting start during RUN must be ignored
    @(negedge clk);
    run_op(0, 1'b0, 8'h12, 8'h34, 3);

    // Reset in RUN cycle 4 aborts the operation
    @(negedge clk);
    mode   = 1'b0;
    a      = 8'hC3;
    b      = 8'h21;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    check_val("pre_abort_busy", busy1, 1);
    rst = 1'b1;
    #1;
    check_val("abort_busy", busy1, 0);
    check_val("abort_done", done1, 0);
    check_val("abort_result", result1, 0);
    check_val("abort_c_out", c_out1, 0);
    check_val("abort_ovf", ovf1, 0);
    check_val("abort_zero", zero1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done1 || busy1) saw = 1'b1;
    end
    check_val("abort_no_done", saw, 0);
    run_op(0, 1'b1, 8'h40, 8'hC0, 0);

    // Random operations, mostly back-to-back
    for (int i = 0; i < 16; i++) begin
      run_op(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // DIGIT=4 instance: latency 3, back-to-back
    repeat (2) @(negedge clk);
    run_op(1, 1'b0, 8'h7F, 8'h01, 0);
    run_op(1, 1'b1, 8'h80, 8'h01, 0);
    run_op(1, 1'b1, 8'h03, 8'h05, 0);
    for (int i = 0; i < 8; i++) begin
      run_op(1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 0);
    end

    repeat (4) @(negedge clk);
    check_val("q1_drained", q1.size(), 0);
    check_val("q4_drained", q4.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
